alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle integer ALU for the CPU datapath. It replaces the single-cycle add/sub/mul/div unit with a registered unit that adds rem/and/or/xor and supports any operand width. Add, sub, mul and logic ops complete in one cycle; div and rem run on an iterative restoring divider. Valid/ready handshakes on both sides let the pipeline stall on long operations.

## Interface
- `WIDTH`, default 32: operand and result width, at least 2.
- `clk` (input, 1): clock, rising edge.
- `rst` (input, 1): synchronous, active-high reset.
- `in_valid` (input, 1): operands and op are valid.
- `in_ready` (output, 1): unit can accept a request.
- `a` (input, WIDTH): operand A, unsigned.
- `b` (input, WIDTH): operand B, unsigned.
- `sel` (input, 3): operation code, type `alu_op_t`.
- `out_valid` (output, 1): result is valid.
- `out_ready` (input, 1): consumer accepts the result.
- `out` (output, WIDTH): result.
- `div_by_zero` (output, 1): flag, valid while `out_valid` is high.

## Operation
- Opcodes (`sel`):
  - 0 ADD: `a + b` mod 2^WIDTH.
  - 1 SUB: `a - b` mod 2^WIDTH.
  - 2 MUL: low WIDTH bits of `a * b`.
  - 3 DIV: `a / b`.
  - 4 REM: `a % b`.
  - 5 AND, 6 OR, 7 XOR.
- All arithmetic is unsigned. Carries and the upper product half are discarded.
- Divide by zero, for DIV or REM with `b == 0`:
  - DIV returns all ones; REM returns `a`.
  - `div_by_zero` is 1.
  - Completes in 1 cycle; the divider is not started.
- FSM states:
  - IDLE: `in_ready`=1. On accept (`in_valid && in_ready`):
    - DIV or REM with `b != 0` → DIV_BUSY, operands loaded into the divider, counter=0.
    - Otherwise → DONE with the result registered.
  - DIV_BUSY: `in_ready`=0. One quotient bit is produced per cycle. When counter reaches WIDTH-1, the result is registered → DONE.
  - DONE: `out_valid`=1, `in_ready`=0.
    - `out`, `div_by_zero` and all internal state hold until `out_ready`=1.
    - `out_valid && out_ready` → IDLE.
- Inputs are sampled only on the accept cycle. Changes to `a`, `b` or `sel` afterwards have no effect.
- `in_valid` while not in IDLE is ignored. It is not queued.
- Reset values: state=IDLE, `out`=0, `out_valid`=0, `div_by_zero`=0, counter=0, `in_ready`=1 in the cycle after `rst`.
- Reset in DIV_BUSY or DONE aborts the operation. No `out_valid` pulse follows.

## Timing
- `in_ready` and `out_valid` are decoded from the state register only; there is no combinational path from `in_valid` or `out_ready`.
- Single-cycle ops: accepted at edge N, `out_valid`=1 after edge N+1.
- DIV/REM with `b != 0`: accepted at edge N, `out_valid`=1 after edge N+WIDTH+1.
- Throughput, single-cycle ops with `out_ready` held high: one result per 2 cycles. Accept and retire never happen in the same cycle.
- Counter width is `$clog2(WIDTH)`. The divider step uses a WIDTH+1-bit partial remainder for subtract and compare.

## Structure
- Package `alu_pkg`:
  - `alu_op_t`: 3-bit enum, values `OP_ADD` … `OP_XOR` as listed above.
  - `state_t`: enum IDLE / DIV_BUSY / DONE.
- Sub-module `alu_div_iter #(WIDTH)`:
  - Ports: `clk`, `rst`, `start`, `dividend`, `divisor`, `quotient`, `remainder`, `done`.
  - One restoring step per cycle; `done` pulses on the final step.
- Top level holds the FSM, the single-cycle datapath mux and the output register.

## Test plan
1. WIDTH=32, ADD `a`=5, `b`=7 → `out`=12, `out_valid` 1 cycle after accept, `div_by_zero`=0. SUB 3−5 → `0xFFFFFFFE`.
2. MUL `0x00010000` × `0x00010003` → `0x00030000`. XOR `0xF0F0F0F0 ^ 0xFFFF0000` → `0x0F0FF0F0`.
3. DIV 100/7 → 14; REM 100%7 → 2. `out_valid` exactly 33 cycles after accept; `in_ready`=0 throughout.
4. DIV `0x1234`/0 → `0xFFFFFFFF` with `div_by_zero`=1. REM `0x1234`%0 → `0x1234`. Both complete in 1 cycle.
5. Backpressure: `out_ready`=0 for 10 cycles after ADD 1+1 → `out`=2 and `out_valid` held steady, `in_valid` pulses ignored. `out_ready`=1 → IDLE next cycle.
6. Assert `rst` 10 cycles into a DIV → `out_valid`=0 and `in_ready`=1 after reset. A following DIV 9/3 returns 3 correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multi-cycle ALU.
//   alu_op_t : 3-bit operation code carried on the request side.
//   state_t  : control FSM states of alu_mc, also exported for debug.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_REM = 3'd4,
      OP_AND = 3'd5,
      OP_OR  = 3'd6,
      OP_XOR = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_BUSY = 2'd1,
      DONE     = 2'd2
   } state_t;

   // DIV and REM are the only ops that may use the iterative divider.
   function automatic logic is_div_op(alu_op_t op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bus of the multi-cycle ALU.
//   request : in_valid, in_ready, a, b, sel
//   response: out_valid, out_ready, out, div_by_zero
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its payload steady until that edge; ready
// never depends combinationally on valid. div_by_zero is only meaningful
// while out_valid is high.
// master: drives requests and consumes results; slave: the ALU.
interface alu_mc_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   alu_op_t          sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             div_by_zero;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, out, div_by_zero
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, out, div_by_zero
   );
endinterface

// File: rtl/alu_div_iter.sv
// alu_div_iter: iterative unsigned restoring divider, one quotient bit
// per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   start               : load dividend/divisor and begin (divisor != 0)
//   dividend, divisor   : operands, sampled only when start is high
//   quotient, remainder : result of the step taken this cycle; final
//                         when done is high
//   done                : high during the final step
module alu_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] q_r;   // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] r_r;   // partial remainder, always < divisor
   logic [WIDTH-1:0] d_r;
   logic [CW-1:0]    cnt;
   logic             busy;

   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   // shifted can reach 2*divisor-1, so the compare needs WIDTH+1 bits;
   // when it succeeds the difference is below divisor and fits WIDTH bits.
   always_comb begin
      shifted = {r_r, q_r[WIDTH-1]};
      ge      = shifted >= {1'b0, d_r};
      r_next  = ge ? (shifted[WIDTH-1:0] - d_r) : shifted[WIDTH-1:0];
      q_next  = {q_r[WIDTH-2:0], ge};
   end

   assign quotient  = q_next;
   assign remainder = r_next;
   assign done      = busy && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r  <= '0;
         r_r  <= '0;
         d_r  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         q_r  <= dividend;
         r_r  <= '0;
         d_r  <= divisor;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         q_r <= q_next;
         r_r <= r_next;
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle unsigned integer ALU.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : alu_mc_if slave (request a/b/sel, response out/div_by_zero)
//   dbg_state : current control FSM state
// ADD/SUB/MUL/logic ops and divide-by-zero finish one cycle after accept;
// DIV/REM with a nonzero divisor run WIDTH steps on alu_div_iter.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   alu_mc_if.slave  bus,
   output state_t   dbg_state
);
   state_t           state;
   logic [WIDTH-1:0] out_r;
   logic             dbz_r;
   logic             rem_sel;   // latched at accept: return remainder

   logic             accept;
   logic             b_zero;
   logic             start_div;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_r;
   logic             div_done;

   assign accept    = (state == IDLE) && bus.in_valid;
   assign b_zero    = (bus.b == '0);
   assign start_div = accept && is_div_op(bus.sel) && !b_zero;

   // Single-cycle result. The DIV/REM arms only matter for b == 0.
   always_comb begin
      alu_res = '0;
      unique case (bus.sel)
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         OP_MUL:  alu_res = bus.a * bus.b;
         OP_DIV:  alu_res = '1;
         OP_REM:  alu_res = bus.a;
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         default: alu_res = '0;
      endcase
   end

   alu_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (start_div),
      .dividend  (bus.a),
      .divisor   (bus.b),
      .quotient  (div_q),
      .remainder (div_r),
      .done      (div_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         out_r   <= '0;
         dbz_r   <= 1'b0;
         rem_sel <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (start_div) begin
                     rem_sel <= (bus.sel == OP_REM);
                     state   <= DIV_BUSY;
                  end else begin
                     out_r <= alu_res;
                     dbz_r <= is_div_op(bus.sel) && b_zero;
                     state <= DONE;
                  end
               end
            end
            DIV_BUSY: begin
               if (div_done) begin
                  out_r <= rem_sel ? div_r : div_q;
                  dbz_r <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake outputs come from the state register only.
   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.out         = out_r;
   assign bus.div_by_zero = dbz_r;
   assign dbg_state       = state;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc at WIDTH=32 with a plain
// arithmetic reference model and an expected-result queue.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;

   logic   clk;
   logic   rst;
   state_t dbg_state;

   int n_checks;
   int n_fail;
   logic [W-1:0] exp_q[$];

   alu_mc_if #(.WIDTH(W)) bus ();

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input alu_op_t op, output logic dz);
      logic [2*W-1:0] prod;
      logic [W-1:0]   r;
      dz = 1'b0;
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (op)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_MUL: r = prod[W-1:0];
         OP_DIV: begin
            if (b == 0) begin r = {W{1'b1}}; dz = 1'b1; end
            else r = a / b;
         end
         OP_REM: begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else r = a % b;
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   function automatic int ref_latency(input logic [W-1:0] b, input alu_op_t op);
      if ((op == OP_DIV || op == OP_REM) && b != 0) return W + 1;
      return 1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sel       = OP_ADD;
   endtask

   // One complete transaction: present, accept, wait for result, optionally
   // hold backpressure for 'hold' cycles with ignored in_valid pulses, retire.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input alu_op_t op,
                        input int hold, input string name);
      logic [W-1:0] er;
      logic [W-1:0] got;
      logic         edz;
      logic         busy_ok;
      logic         hold_ok;
      int           lat;
      int           elat;
      er   = ref_result(ta, tb, op, edz);
      elat = ref_latency(tb, op);
      exp_q.push_back(er);

      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready_before: got %b want 1", name, bus.in_ready);
      end
      bus.a = ta; bus.b = tb; bus.sel = op; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk);
      lat = 1;
      #1;
      // Later input changes must not affect the accepted operation.
      bus.in_valid = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.sel = alu_op_t'($urandom_range(0, 7));
      busy_ok = 1'b1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         #1;
      end
      got = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: out_valid never rose within %0d cycles", name, lat);
      end
      n_checks++;
      if (bus.out !== got) begin
         n_fail++;
         $display("FAIL %s result: got %h want %h", name, bus.out, got);
      end
      n_checks++;
      if (bus.div_by_zero !== edz) begin
         n_fail++;
         $display("FAIL %s div_by_zero: got %b want %b", name, bus.div_by_zero, edz);
      end
      n_checks++;
      if (lat != elat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
      end
      n_checks++;
      if (!busy_ok) begin
         n_fail++;
         $display("FAIL %s in_ready_busy: got 1 while busy want 0", name);
      end

      if (hold > 0) begin
         hold_ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            bus.in_valid = $urandom_range(0, 1);
            bus.a = $urandom; bus.b = $urandom;
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.out !== got || bus.div_by_zero !== edz ||
                bus.in_ready !== 1'b0) hold_ok = 1'b0;
         end
         bus.in_valid = 1'b0;
         n_checks++;
         if (!hold_ok) begin
            n_fail++;
            $display("FAIL %s backpressure_hold: out=%h valid=%b, want %h held", name,
                     bus.out, bus.out_valid, got);
         end
      end

      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s retire: out_valid=%b in_ready=%b want 0/1", name,
                  bus.out_valid, bus.in_ready);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== '0 ||
          bus.div_by_zero !== 1'b0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_values: in_ready=%b out_valid=%b out=%h dbz=%b state=%0d want 1/0/0/0/IDLE",
                  bus.in_ready, bus.out_valid, bus.out, bus.div_by_zero, dbg_state);
      end
   endtask

   task automatic test_directed();
      do_op(32'd5, 32'd7, OP_ADD, 0, "add_5_7");
      do_op(32'd3, 32'd5, OP_SUB, 0, "sub_3_5");
      do_op(32'h0001_0000, 32'h0001_0003, OP_MUL, 0, "mul_hi");
      do_op(32'hF0F0_F0F0, 32'hFFFF_0000, OP_XOR, 0, "xor");
      do_op(32'hF0F0_F0F0, 32'hFFFF_0000, OP_AND, 0, "and");
      do_op(32'hF0F0_F0F0, 32'h0000_FFFF, OP_OR, 0, "or");
      do_op(32'd100, 32'd7, OP_DIV, 0, "div_100_7");
      do_op(32'd100, 32'd7, OP_REM, 0, "rem_100_7");
      do_op(32'h1234, 32'd0, OP_DIV, 0, "div_by_zero");
      do_op(32'h1234, 32'd0, OP_REM, 0, "rem_by_zero");
      do_op(32'hFFFF_FFFF, 32'd1, OP_DIV, 0, "div_max_1");
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_REM, 0, "rem_max_max");
      do_op(32'd3, 32'hFFFF_FFFF, OP_DIV, 0, "div_small_big");
   endtask

   task automatic test_backpressure();
      do_op(32'd1, 32'd1, OP_ADD, 10, "backpressure_add");
      do_op(32'd50, 32'd6, OP_REM, 4, "backpressure_rem");
   endtask

   task automatic test_reset_abort();
      logic quiet;
      @(negedge clk);
      bus.a = 32'd1000; bus.b = 32'd3; bus.sel = OP_DIV; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_abort: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
      quiet = 1'b1;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0) quiet = 1'b0;
      end
      bus.out_ready = 1'b0;
      n_checks++;
      if (!quiet) begin
         n_fail++;
         $display("FAIL reset_abort_no_pulse: got out_valid=1 after abort want 0");
      end
      do_op(32'd9, 32'd3, OP_DIV, 0, "div_9_3_after_abort");
   endtask

   task automatic test_random();
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      alu_op_t      rop;
      for (int i = 0; i < 24; i++) begin
         ra  = $urandom;
         rop = alu_op_t'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: rb = '0;
            1: rb = W'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         do_op(ra, rb, rop, $urandom_range(0, 2), "random");
      end
   endtask

   // out_ready held high, in_valid held high: results every other cycle.
   task automatic test_back_to_back();
      logic         edz;
      int           accepted;
      int           results;
      logic         overlap;
      logic         data_ok;
      logic [W-1:0] want;
      accepted = 0; results = 0; overlap = 1'b0; data_ok = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.a = $urandom; bus.b = $urandom;
         bus.sel = alu_op_t'($urandom_range(0, 1) ? OP_ADD : OP_XOR);
         if (bus.in_ready === 1'b1) begin
            exp_q.push_back(ref_result(bus.a, bus.b, bus.sel, edz));
            accepted++;
         end
         @(posedge clk);
         #1;
         if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) overlap = 1'b1;
         if (bus.out_valid === 1'b1) begin
            results++;
            if (exp_q.size() == 0) data_ok = 1'b0;
            else begin
               want = exp_q.pop_front();
               if (bus.out !== want) data_ok = 1'b0;
            end
         end
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      exp_q.delete();
      n_checks++;
      if (results != 4 || accepted != 4) begin
         n_fail++;
         $display("FAIL back_to_back_rate: got %0d accepts %0d results want 4/4", accepted, results);
      end
      n_checks++;
      if (overlap) begin
         n_fail++;
         $display("FAIL back_to_back_overlap: got in_ready and out_valid both 1 want exclusive");
      end
      n_checks++;
      if (!data_ok) begin
         n_fail++;
         $display("FAIL back_to_back_data: results did not match accepted requests");
      end
   endtask

   // ---------------- main sequence + report ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      test_random();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
